// File: rtl/pv2000_pkg.sv
// Shared definitions for the PV-2000 cartridge loader: FSM state encoding,
// default image/erase address constants and the load-address helper.
// Macro CART_LOADER_ERASE_EN adds the ERASE state to the encoding.
package pv2000_pkg;

    localparam logic [15:0] CART_BASE_DEF = 16'hC000;
    localparam logic [15:0] ERASE_LO_DEF  = 16'h7000;
    localparam logic [15:0] ERASE_LAST    = 16'hFFFF;
    localparam int          HOLD_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
`ifdef CART_LOADER_ERASE_EN
        ST_ERASE = 2'd2,
`endif
        ST_HOLD  = 2'd3
    } loader_state_t;

    // BIOS images land at their own address; cartridge images are shifted by
    // the cartridge base and wrap within the 64 KiB console space.
    function automatic logic [15:0] load_addr(input logic [7:0]  idx,
                                              input logic [15:0] a,
                                              input logic [15:0] base);
        return (idx == 8'h00) ? a : a + base;
    endfunction

endpackage

// File: rtl/cart_eraser.sv
// Erase-address sequencer: after a start pulse walks addr from ERASE_LO up to
// 16'hFFFF, asserting we every other cycle (write, idle, write, ...).
// Ports: clk/reset, start in; addr, we, done (high with the final write) out.
module cart_eraser
    import pv2000_pkg::*;
#(
    parameter logic [15:0] ERASE_LO = ERASE_LO_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] addr,
    output logic        we,
    output logic        done
);

    logic        active_q, active_d;
    logic        phase_q, phase_d;   // 0 = write cycle, 1 = idle cycle
    logic [15:0] addr_q, addr_d;

    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        addr_d   = addr_q;
        if (start) begin
            active_d = 1'b1;
            phase_d  = 1'b0;
            addr_d   = ERASE_LO;
        end else if (active_q) begin
            if (!phase_q) begin
                // Stop on the last address instead of incrementing, so the
                // counter can never roll over to 0.
                if (addr_q == ERASE_LAST) begin
                    active_d = 1'b0;
                    phase_d  = 1'b0;
                end else begin
                    phase_d = 1'b1;
                end
            end else begin
                phase_d = 1'b0;
                addr_d  = addr_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            addr_q   <= ERASE_LO;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            addr_q   <= addr_d;
        end
    end

    assign addr = addr_q;
    assign we   = active_q && !phase_q;
    assign done = we && (addr_q == ERASE_LAST);

endmodule

// File: rtl/cart_loader.sv
// Cartridge/BIOS loader: muxes console RAM port between CPU passthrough, HPS
// image download (1-cycle registered write) and optional cartridge-RAM erase,
// then holds sys_reset for RST_HOLD cycles. Optional erase: CART_LOADER_ERASE_EN.
// Ports: clk/reset; ioctl_* download in; erase_req; cpu_* in; mem_* out; busy, sys_reset.
module cart_loader
    import pv2000_pkg::*;
#(
    parameter int unsigned RST_HOLD  = 255,
    parameter logic [15:0] CART_BASE = CART_BASE_DEF,
    parameter logic [15:0] ERASE_LO  = ERASE_LO_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        erase_req,
    input  logic [15:0] cpu_a,
    input  logic        cpu_we_n,
    input  logic [7:0]  cpu_d,
    output logic [15:0] mem_a,
    output logic        mem_we,
    output logic [7:0]  mem_d,
    output logic        busy,
    output logic        sys_reset
);

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);

    loader_state_t     state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;

    // Download write stage: one register between the strobe and the RAM.
    logic        ld_we_q, ld_we_d;
    logic [15:0] ld_a_q, ld_a_d;
    logic [7:0]  ld_dat_q, ld_dat_d;

    always_comb begin
        ld_a_d   = ld_a_q;
        ld_dat_d = ld_dat_q;
        // Bytes beyond the 64 KiB window are silently dropped.
        ld_we_d  = (state_q == ST_LOAD) && ioctl_wr && (ioctl_addr[24:16] == 9'd0);
        if (ld_we_d) begin
            ld_a_d   = load_addr(ioctl_index, ioctl_addr[15:0], CART_BASE);
            ld_dat_d = ioctl_dout;
        end
    end

`ifdef CART_LOADER_ERASE_EN
    logic        req_q;
    logic        pend_q, pend_d;
    logic        er_start;
    logic        er_we;
    logic        er_done;
    logic [15:0] er_a;

    // A download waiting in IDLE wins; the erase stays pending behind it.
    assign er_start = (state_q == ST_IDLE) && !ioctl_download && pend_q;

    // Edges seen while already pending merge into the same single erase.
    always_comb begin
        pend_d = (pend_q && !er_start) || (erase_req && !req_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            req_q  <= erase_req;
            pend_q <= pend_d;
        end
    end

    cart_eraser #(
        .ERASE_LO (ERASE_LO)
    ) u_eraser (
        .clk   (clk),
        .reset (reset),
        .start (er_start),
        .addr  (er_a),
        .we    (er_we),
        .done  (er_done)
    );
`else
    logic [16:0] unused_erase;
    assign unused_erase = {erase_req, ERASE_LO};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ioctl_download) begin
                    state_d = ST_LOAD;
`ifdef CART_LOADER_ERASE_EN
                end else if (pend_q) begin
                    state_d = ST_ERASE;
`endif
                end
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
`ifdef CART_LOADER_ERASE_EN
            ST_ERASE: begin
                if (er_done) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
`endif
            ST_HOLD: begin
                if (ioctl_download) begin
                    state_d = ST_LOAD;
                end else begin
                    // Leave when this decrement brings the counter to 0, so
                    // HOLD spans exactly RST_HOLD cycles.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (cnt_q <= 1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_HOLD;
            cnt_q    <= HOLD_INIT;
            ld_we_q  <= 1'b0;
            ld_a_q   <= 16'h0000;
            ld_dat_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_we_q  <= ld_we_d;
            ld_a_q   <= ld_a_d;
            ld_dat_q <= ld_dat_d;
        end
    end

    always_comb begin
        mem_a  = cpu_a;
        mem_d  = cpu_d;
        mem_we = !cpu_we_n;
        busy   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                mem_a  = ld_a_q;
                mem_d  = ld_dat_q;
                mem_we = ld_we_q;
                busy   = 1'b1;
            end
`ifdef CART_LOADER_ERASE_EN
            ST_ERASE: begin
                mem_a  = er_a;
                mem_d  = 8'h00;
                mem_we = er_we;
                busy   = 1'b1;
            end
`endif
            default: ;
        endcase
        // Reset kills any write at once, including CPU passthrough.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    assign sys_reset = (state_q != ST_IDLE);

endmodule

// File: doc/cart_loader.md
CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 Parameter RST_HOLD, default 255: cycles sys_reset stays high after a load or erase ends.
REQ-002 Parameter CART_BASE, default 16'hC000: address offset for cartridge images (ioctl_index != 0).
REQ-003 Parameter ERASE_LO, default 16'h7000: first erased address; the last erased address is 16'hFFFF.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ioctl_download  in  1  download window from the HPS.
REQ-007 ioctl_index  in  8  image type; 0 = BIOS, other = cartridge.
REQ-008 ioctl_wr  in  1  one-cycle byte strobe.
REQ-009 ioctl_addr  in  25  byte address within the image.
REQ-010 ioctl_dout  in  8  byte data.
REQ-011 erase_req  in  1  level input; a rising edge requests a cartridge-RAM erase.
REQ-012 cpu_a  in  16  console RAM address.
REQ-013 cpu_we_n  in  1  console write enable, active-low.
REQ-014 cpu_d  in  8  console write data.
REQ-015 mem_a  out  16  RAM address.
REQ-016 mem_we  out  1  RAM write enable, active-high.
REQ-017 mem_d  out  8  RAM write data.
REQ-018 busy  out  1  high in LOAD or ERASE.
REQ-019 sys_reset  out  1  console reset request.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, ERASE and HOLD.
- IDLE->LOAD on ioctl_download=1.
- IDLE->ERASE on a pending erase.
- LOAD->HOLD on ioctl_download falling.
- ERASE->HOLD after the write to 16'hFFFF.
- HOLD->IDLE when the hold counter reaches 0.
REQ-021 In IDLE and HOLD, mem_a/mem_we/mem_d SHALL equal cpu_a/~cpu_we_n/cpu_d combinationally.
REQ-022 In LOAD, a cycle with ioctl_wr=1 SHALL produce, one cycle later, mem_we=1, mem_d=ioctl_dout and mem_a as follows:
- ioctl_index==0: mem_a = ioctl_addr[15:0].
- otherwise: mem_a = ioctl_addr[15:0]+CART_BASE, modulo 2^16.
REQ-023 In LOAD, writes with ioctl_addr[24:16]!=0 SHALL be dropped (mem_we stays 0).
REQ-024 In LOAD with no write this cycle, mem_we SHALL be 0 and console writes SHALL be blocked.
REQ-025 ERASE SHALL write 8'h00 to every address from ERASE_LO to 16'hFFFF inclusive, alternating a write cycle and an idle cycle, i.e. 2 cycles per byte.
REQ-026 The ERASE address counter SHALL terminate at 16'hFFFF; it SHALL NOT wrap to 0 and SHALL NOT issue a write to 0.
REQ-027 An erase_req rising edge SHALL set an erase-pending flag.
- In LOAD or ERASE, the flag SHALL stay pending and run on the next entry to IDLE.
- Repeated edges SHALL coalesce into one erase.
REQ-028 On entry to HOLD, the hold counter SHALL load RST_HOLD.
- The counter SHALL decrement each cycle.
- A new download in HOLD SHALL go directly to LOAD.
REQ-029 sys_reset SHALL be high whenever the state is not IDLE.
REQ-030 busy SHALL be high exactly in LOAD and ERASE.

Reset
REQ-031 While reset is high: state = HOLD, counter = RST_HOLD, pending = 0, erase address = ERASE_LO, mem_we = 0, busy = 0, sys_reset = 1.
REQ-032 Reset during LOAD or ERASE SHALL abort the operation immediately. No write SHALL occur after reset is asserted.

Configuration
REQ-033 With CART_LOADER_ERASE_EN defined, the erase logic (REQ-025..027) SHALL be present.
REQ-034 Without CART_LOADER_ERASE_EN, the ERASE state and pending flag SHALL be absent and erase_req SHALL be ignored; all other behaviour is unchanged.

Structure
REQ-035 The state enum, CART_BASE and ERASE_LO defaults SHALL live in the shared package pv2000_pkg.
REQ-036 The erase-address sequencer SHALL be one sub-module, cart_eraser.
- Inputs: start.
- Outputs: addr, we, done.

Verification
REQ-037 Load BIOS: index 0, bytes 0x3E and 0x55 at addr 0x0000/0x0001 -> mem writes to 0x0000/0x0001 one cycle after each strobe; sys_reset stays high 255 cycles after the download falls.
REQ-038 Load cartridge: index 1, addr 0x3FFF with data 0xA5 -> write to 0xFFFF. Addr 0x4000 -> write to 0x0000 (wrap). Addr 0x10000 -> no write.
REQ-039 Erase: pulse erase_req -> exactly 0x9000 writes of 0x00 covering 0x7000..0xFFFF at 2-cycle spacing, no write to 0x0000, then HOLD for 255 cycles.
REQ-040 erase_req pulse during LOAD -> the erase starts right after HOLD ends; two pulses during LOAD -> only one erase runs.
REQ-041 Reset asserted midway through an erase (at address 0x8000) -> mem_we=0 immediately; after release the erase does not resume and sys_reset stays high 255 cycles.
REQ-042 Idle passthrough: cpu_we_n=0, cpu_a=0x1234, cpu_d=0x77 -> mem_we=1, mem_a=0x1234, mem_d=0x77 in the same cycle. Build without CART_LOADER_ERASE_EN: erase_req has no effect.
